// File: rtl/chip_pkg.sv
// Shared opcode/state definitions for the chip sequencer and its helpers.
package chip_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE     = 3'd0,
    OP_LOAD_SEED = 3'd1,
    OP_INFER     = 3'd2,
    OP_READ1     = 3'd3,
    OP_READ8     = 3'd4,
    OP_LOAD_MEM  = 3'd5
  } chip_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_RESP
  } chip_state_t;

  function automatic logic op_is_legal(logic [OP_W-1:0] op);
    return op <= OP_W'(5);
  endfunction

  function automatic logic op_is_read(chip_op_t op);
    return (op == OP_READ1) || (op == OP_READ8);
  endfunction

endpackage

// File: rtl/chip_pulse_timer.sv
// Down-counter that times the strobe phase; a zero length is stretched to one cycle.
module chip_pulse_timer #(
  parameter int PLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [PLEN_W-1:0] load_len,
  input  logic              en,
  output logic              done
);

  logic [PLEN_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (load_len == '0) ? PLEN_W'(1) : load_len;
    end else if (en && (count != '0)) begin
      count <= count - PLEN_W'(1);
    end
  end

  // done marks the final cycle of the pulse, so the FSM can leave on that edge
  assign done = (count == PLEN_W'(1));

endmodule

// File: rtl/chip_sequencer.sv
// Command-driven sequencer that turns one accepted command into a
// SETUP / PULSE / HOLD strobe sequence on the chip-side pins.
module chip_sequencer
  import chip_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SEED_W = 8,
  parameter int NB_OUT = 4,
  parameter int PLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_row,
  input  logic [ADDR_W-1:0] cmd_col,
  input  logic [SEED_W-1:0] cmd_seed,
  input  logic              cmd_data,
  input  logic              cmd_stoch,
  input  logic [PLEN_W-1:0] pulse_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NB_OUT-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              chip_clk,
  output logic              CBL,
  output logic              CBLEN,
  output logic              CWL,
  output logic              inference,
  output logic              load_seed,
  output logic              read_1,
  output logic              read_8,
  output logic              load_mem,
  output logic              read_out,
  output logic              stoch_log,
  output logic [ADDR_W-1:0] addr_full_row,
  output logic [ADDR_W-1:0] addr_full_col,
  output logic [SEED_W-1:0] seeds,
  input  logic [NB_OUT-1:0] bit_out
);

  chip_state_t state;
  chip_op_t    op_q;
  logic        pulse_done;

  chip_pulse_timer #(.PLEN_W(PLEN_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == ST_IDLE) && cmd_valid),
    .load_len (pulse_len),
    .en       (state == ST_PULSE),
    .done     (pulse_done)
  );

  // Every output is set on the edge that enters the state it belongs to,
  // so all chip pins come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= OP_WRITE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      chip_clk      <= 1'b0;
      CBL           <= 1'b0;
      CBLEN         <= 1'b0;
      CWL           <= 1'b0;
      inference     <= 1'b0;
      load_seed     <= 1'b0;
      read_1        <= 1'b0;
      read_8        <= 1'b0;
      load_mem      <= 1'b0;
      read_out      <= 1'b0;
      stoch_log     <= 1'b0;
      addr_full_row <= '0;
      addr_full_col <= '0;
      seeds         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (!op_is_legal(cmd_op)) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state         <= ST_SETUP;
              op_q          <= chip_op_t'(cmd_op);
              addr_full_row <= cmd_row;
              addr_full_col <= cmd_col;
              seeds         <= cmd_seed;
              CBLEN         <= (cmd_op == OP_WRITE);
              CBL           <= (cmd_op == OP_WRITE) && cmd_data;
              stoch_log     <= (cmd_op == OP_INFER) && cmd_stoch;
            end
          end
        end
        ST_SETUP: begin
          state     <= ST_PULSE;
          CWL       <= (op_q == OP_WRITE);
          load_seed <= (op_q == OP_LOAD_SEED);
          inference <= (op_q == OP_INFER);
          read_1    <= (op_q == OP_READ1);
          read_8    <= (op_q == OP_READ8);
          read_out  <= op_is_read(op_q);
          load_mem  <= (op_q == OP_LOAD_MEM);
          chip_clk  <= (op_q == OP_INFER);
        end
        ST_PULSE: begin
          if (pulse_done) begin
            state     <= ST_HOLD;
            CWL       <= 1'b0;
            load_seed <= 1'b0;
            inference <= 1'b0;
            read_1    <= 1'b0;
            read_8    <= 1'b0;
            read_out  <= 1'b0;
            load_mem  <= 1'b0;
            chip_clk  <= 1'b0;
            if (op_is_read(op_q)) begin
              rsp_data <= bit_out;
            end
          end else if (op_q == OP_INFER) begin
            chip_clk <= ~chip_clk;
          end
        end
        ST_HOLD: begin
          addr_full_row <= '0;
          addr_full_col <= '0;
          seeds         <= '0;
          CBL           <= 1'b0;
          CBLEN         <= 1'b0;
          stoch_log     <= 1'b0;
          if (op_is_read(op_q)) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip_sequencer.sv
// Scoreboard bench for chip_sequencer: directed scenarios plus a randomized run,
// checked against a per-command model of pulse counts, windows and responses.
module tb_chip_sequencer;
  import chip_pkg::*;

  localparam int ADDR_W = 8;
  localparam int SEED_W = 8;
  localparam int NB_OUT = 4;
  localparam int PLEN_W = 4;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_row;
  logic [ADDR_W-1:0] cmd_col;
  logic [SEED_W-1:0] cmd_seed;
  logic              cmd_data;
  logic              cmd_stoch;
  logic [PLEN_W-1:0] pulse_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NB_OUT-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              chip_clk, CBL, CBLEN, CWL, inference, load_seed;
  logic              read_1, read_8, load_mem, read_out, stoch_log;
  logic [ADDR_W-1:0] addr_full_row;
  logic [ADDR_W-1:0] addr_full_col;
  logic [SEED_W-1:0] seeds;
  logic [NB_OUT-1:0] bit_out;

  chip_sequencer #(
    .ADDR_W(ADDR_W), .SEED_W(SEED_W), .NB_OUT(NB_OUT), .PLEN_W(PLEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_seed(cmd_seed),
    .cmd_data(cmd_data), .cmd_stoch(cmd_stoch), .pulse_len(pulse_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .chip_clk(chip_clk), .CBL(CBL), .CBLEN(CBLEN), .CWL(CWL),
    .inference(inference), .load_seed(load_seed), .read_1(read_1),
    .read_8(read_8), .load_mem(load_mem), .read_out(read_out),
    .stoch_log(stoch_log), .addr_full_row(addr_full_row),
    .addr_full_col(addr_full_col), .seeds(seeds), .bit_out(bit_out)
  );

  logic [34:0] chip_bus;
  assign chip_bus = {chip_clk, CBL, CBLEN, CWL, inference, load_seed, read_1,
                     read_8, load_mem, read_out, stoch_log,
                     addr_full_row, addr_full_col, seeds};

  typedef struct {
    logic [2:0] op;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] seed;
    logic       data;
    logic       stoch;
    int         plen;
    logic [3:0] bits;
  } exp_op_t;

  typedef struct {
    logic [3:0] data;
    logic       err;
  } exp_rsp_t;

  exp_op_t  op_q[$];
  exp_rsp_t rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit         fixed_ready  = 1'b1;
  bit         rand_ready   = 1'b0;
  bit         lat_check_en = 1'b1;
  bit         prev_b2b     = 1'b0;
  int         prev_acc     = 0;
  int         prev_lat     = 0;
  logic [3:0] cur_bits     = 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int eff_len(int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic bit is_read_op(logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

  // Accept-to-accept distance when the next command is already waiting and rsp_ready is high
  function automatic int model_latency(exp_op_t e);
    if (e.op > 3'd5) return 2;
    if (is_read_op(e.op)) return eff_len(e.plen) + 4;
    return eff_len(e.plen) + 3;
  endfunction

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  // bit_out carries the expected word only while a read strobe is up
  initial begin
    bit_out = '0;
    forever begin
      @(negedge clk);
      bit_out = (read_1 || read_8) ? cur_bits : 4'($urandom);
    end
  end

  // Must be called between a posedge and the following posedge, away from the edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] row,
                               input logic [7:0] col, input logic [7:0] seed,
                               input logic data, input logic stoch,
                               input logic [3:0] plen, input logic [3:0] bits,
                               input bit keep_valid, output int acc_cyc);
    exp_op_t  e;
    exp_rsp_t r;
    bit       accepted;
    cmd_op    = op;
    cmd_row   = row;
    cmd_col   = col;
    cmd_seed  = seed;
    cmd_data  = data;
    cmd_stoch = stoch;
    pulse_len = plen;
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    acc_cyc   = -1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (cmd_ready) begin
        e.op = op; e.row = row; e.col = col; e.seed = seed;
        e.data = data; e.stoch = stoch; e.plen = int'(plen); e.bits = bits;
        op_q.push_back(e);
        if (op > 3'd5) begin
          r.data = 4'h0; r.err = 1'b1; rsp_q.push_back(r);
        end else if (is_read_op(op)) begin
          r.data = bits; r.err = 1'b0; rsp_q.push_back(r);
        end
        cur_bits = bits;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      prev_b2b  = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (prev_b2b) checkOutput("b2b_latency", 64'(acc_cyc - prev_acc), 64'(prev_lat));
    prev_acc = acc_cyc;
    prev_lat = model_latency(e);
    prev_b2b = keep_valid && lat_check_en;
    cmd_op    = 3'($urandom);
    cmd_row   = 8'($urandom);
    cmd_col   = 8'($urandom);
    cmd_seed  = 8'($urandom);
    cmd_data  = 1'($urandom);
    cmd_stoch = 1'($urandom);
    pulse_len = 4'($urandom);
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  // Chip-side monitor: each busy window is one command; counts are compared when it closes.
  bit in_frame = 1'b0;
  int c_busy, c_cwl, c_ls, c_inf, c_r1, c_r8, c_rout, c_lm, c_cclk, c_cblen, c_cbl, c_stoch;

  task automatic close_frame();
    exp_op_t e;
    int      p;
    if (op_q.size() == 0) begin
      checkOutput("frame_without_cmd", 64'd1, 64'd0);
      return;
    end
    e = op_q.pop_front();
    p = eff_len(e.plen);
    checkOutput("strobe_counts",
      {8'(c_cwl), 8'(c_ls), 8'(c_inf), 8'(c_r1), 8'(c_r8), 8'(c_rout), 8'(c_lm), 8'(c_cclk)},
      {8'((e.op == 3'd0) ? p : 0), 8'((e.op == 3'd1) ? p : 0),
       8'((e.op == 3'd2) ? p : 0), 8'((e.op == 3'd3) ? p : 0),
       8'((e.op == 3'd4) ? p : 0), 8'(is_read_op(e.op) ? p : 0),
       8'((e.op == 3'd5) ? p : 0), 8'((e.op == 3'd2) ? (p + 1) / 2 : 0)});
    checkOutput("window_counts",
      {40'd0, 8'(c_cblen), 8'(c_cbl), 8'(c_stoch)},
      {40'd0, 8'((e.op == 3'd0) ? p + 2 : 0),
       8'((e.op == 3'd0 && e.data) ? p + 2 : 0),
       8'((e.op == 3'd2 && e.stoch) ? p + 2 : 0)});
    if (e.op <= 3'd5 && !is_read_op(e.op)) checkOutput("busy_cycles", 64'(c_busy), 64'(p + 2));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (busy) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        c_busy = 0; c_cwl = 0; c_ls = 0; c_inf = 0; c_r1 = 0; c_r8 = 0;
        c_rout = 0; c_lm = 0; c_cclk = 0; c_cblen = 0; c_cbl = 0; c_stoch = 0;
      end
      c_busy++;
      c_cwl += int'(CWL);   c_ls += int'(load_seed); c_inf += int'(inference);
      c_r1 += int'(read_1); c_r8 += int'(read_8);    c_rout += int'(read_out);
      c_lm += int'(load_mem); c_cclk += int'(chip_clk); c_cblen += int'(CBLEN);
      c_cbl += int'(CBL);   c_stoch += int'(stoch_log);
      if (CWL || load_seed || inference || read_1 || read_8 || load_mem || CBLEN) begin
        if (op_q.size() == 0)
          checkOutput("unexpected_activity", 64'd1, 64'd0);
        else
          checkOutput("chip_addr_seed", {40'd0, addr_full_row, addr_full_col, seeds},
                      {40'd0, op_q[0].row, op_q[0].col, op_q[0].seed});
      end
    end else begin
      checkOutput("idle_outputs", 64'(chip_bus), 64'd0);
      if (in_frame) begin
        in_frame = 1'b0;
        close_frame();
      end
    end
  end

  // Response monitor: first presentation is scored, later cycles must hold steady.
  bit       have_cur = 1'b0;
  exp_rsp_t cur_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 1'b0;
    end else if (rsp_valid) begin
      if (!have_cur) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
          cur_rsp.data = rsp_data;
          cur_rsp.err  = rsp_err;
        end else begin
          cur_rsp = rsp_q.pop_front();
          checkOutput("rsp_data_err", {59'd0, rsp_data, rsp_err}, {59'd0, cur_rsp.data, cur_rsp.err});
        end
        have_cur = 1'b1;
      end else begin
        checkOutput("rsp_stable", {59'd0, rsp_data, rsp_err}, {59'd0, cur_rsp.data, cur_rsp.err});
      end
      if (rsp_ready) have_cur = 1'b0;
    end
  end

  initial begin
    int acc, rel, r;
    logic [2:0] op;
    cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0; cmd_seed = '0;
    cmd_data = 1'b0; cmd_stoch = 1'b0; pulse_len = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_state", 64'({busy, rsp_valid, rsp_data, rsp_err, chip_bus}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);
    rel = cyc;

    // Back-to-back chain with rsp_ready held high: latencies, windows, seeds
    applyStimulus(3'd0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 4'd3, 4'h0, 1'b1, acc);
    checkOutput("first_accept_edge", 64'(acc - rel), 64'd1);
    applyStimulus(3'd1, 8'h01, 8'h02, 8'h5A, 1'b0, 1'b0, 4'd2, 4'h0, 1'b1, acc);
    applyStimulus(3'd1, 8'h03, 8'h04, 8'hA5, 1'b0, 1'b0, 4'd2, 4'h0, 1'b1, acc);
    applyStimulus(3'd2, 8'h55, 8'h66, 8'h77, 1'b0, 1'b1, 4'd0, 4'h0, 1'b1, acc);
    applyStimulus(3'd7, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 4'd4, 4'h0, 1'b1, acc);
    applyStimulus(3'd3, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 4'd1, 4'h6, 1'b1, acc);
    applyStimulus(3'd2, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 4'd3, 4'h0, 1'b0, acc);

    // READ8 with the response stalled for four cycles
    fixed_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(3'd4, 8'h44, 8'h55, 8'h66, 1'b0, 1'b0, 4'd2, 4'hA, 1'b0, acc);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("read8_rsp_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("read8_rsp_held", 64'({rsp_valid, cmd_ready}), 64'd2);
    end
    fixed_ready = 1'b1;

    // Reset in the second cycle of a five-cycle LOAD_MEM pulse
    applyStimulus(3'd5, 8'h0F, 8'hF0, 8'h3C, 1'b0, 1'b0, 4'd5, 4'h0, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("load_mem_before_reset", 64'(load_mem), 64'd1);
    rst_n = 1'b0;
    op_q.delete();
    rsp_q.delete();
    prev_b2b = 1'b0;
    #1 checkOutput("mid_pulse_reset", 64'({busy, rsp_valid, rsp_data, rsp_err, chip_bus}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rel = cyc;
    applyStimulus(3'd0, 8'hC3, 8'h3C, 8'h00, 1'b0, 1'b0, 4'd1, 4'h0, 1'b0, acc);
    checkOutput("accept_after_reset", 64'(acc - rel), 64'd1);

    // Randomized traffic with random response back-pressure
    lat_check_en = 1'b0;
    rand_ready   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? 3'(r) : 3'($urandom_range(0, 5));
      applyStimulus(op, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), 4'($urandom_range(0, 6)), 4'($urandom),
                    1'($urandom_range(0, 1)), acc);
    end
    cmd_valid  = 1'b0;
    rand_ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("op_queue_drained", 64'(op_q.size()), 64'd0);
    checkOutput("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    checkOutput("final_idle", 64'({cmd_ready, busy, rsp_valid}), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip_sequencer.md
CHIP_SEQUENCER -- requirements
Module: chip_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of chip row and column address buses.
REQ-002 Parameter SEED_W, default 8: width of chip seed bus.
REQ-003 Parameter NB_OUT, default 4: width of chip bit_out (output channel count).
REQ-004 Parameter PLEN_W, default 4: width of the pulse-length input.
REQ-005 One clock; reset is asynchronous and active-low. Ports: clk, then rst_n.
REQ-006 clk  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cmd_valid  in  1; cmd_ready  out  1: command handshake.
REQ-009 cmd_op  in  3  opcode; cmd_row, cmd_col  in  ADDR_W; cmd_seed  in  SEED_W; cmd_data  in  1  write bit; cmd_stoch  in  1  stochastic-log mode.
REQ-010 pulse_len  in  PLEN_W  strobe length in cycles; 0 is treated as 1.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  NB_OUT; rsp_err  out  1: response handshake.
REQ-012 busy  out  1  high whenever not IDLE.
REQ-013 Chip-side outputs: chip_clk, CBL, CBLEN, CWL, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log (1 each), addr_full_row, addr_full_col (ADDR_W), seeds (SEED_W); input bit_out (NB_OUT).

Function
REQ-014 Opcodes SHALL be WRITE=0, LOAD_SEED=1, INFER=2, READ1=3, READ8=4, LOAD_MEM=5; 6, 7 illegal.
REQ-015 States SHALL be IDLE, SETUP, PULSE, HOLD, RESP.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch all cmd_* fields and pulse_len, go SETUP next cycle.
REQ-017 Illegal opcode: skip SETUP/PULSE/HOLD, go directly to RESP with rsp_err=1, rsp_data=0.
REQ-018 SETUP (exactly 1 cycle): drive latched row/col/seed; CBLEN=1 and CBL=cmd_data for WRITE only; stoch_log=cmd_stoch for INFER only; all strobes low.
REQ-019 PULSE: hold for max(pulse_len,1) cycles, asserting the op strobe: WRITE->CWL, LOAD_SEED->load_seed, INFER->inference, READ1->read_1+read_out, READ8->read_8+read_out, LOAD_MEM->load_mem.
REQ-020 chip_clk SHALL toggle every cycle during PULSE for INFER (starting high) and be 0 otherwise.
REQ-021 HOLD (exactly 1 cycle): strobes low, address/data/CBLEN still held; read ops sample bit_out into rsp_data on the last PULSE cycle.
REQ-022 READ1/READ8 go HOLD->RESP; other legal ops go HOLD->IDLE with no response.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&&rsp_ready, then IDLE; cmd_ready=0.
REQ-024 Legal non-read op latency, accept to cmd_ready high again: pulse_len'+3 cycles (pulse_len'=max(pulse_len,1)).
REQ-025 cmd_* changes after acceptance SHALL have no effect on the running op.
REQ-026 All chip-side outputs SHALL be registered; no glitches on strobes.
REQ-027 Outside SETUP/PULSE/HOLD, address, seeds, CBL, CBLEN, stoch_log SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all chip outputs 0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, cmd_ready=1 after release, including mid-PULSE.
REQ-029 First command SHALL be accepted in the first clk edge after rst_n deasserts.

Structure
REQ-030 Package chip_pkg SHALL hold the opcode enum, state enum, and opcode width constant.
REQ-031 Pulse counting SHALL live in sub-module chip_pulse_timer (load, count down, done flag; PLEN_W param).
REQ-032 Target size 150-300 lines RTL.

Verification
REQ-033 WRITE row=0x12 col=0x34 data=1 pulse_len=3 -> CBLEN=1, CBL=1 for 5 cycles, CWL high exactly 3 cycles, cmd_ready back after 6 cycles.
REQ-034 READ8 pulse_len=2, bit_out=0xA -> read_8 and read_out high 2 cycles, rsp_valid with rsp_data=0xA, rsp_err=0; held 4 cycles with rsp_ready=0.
REQ-035 INFER pulse_len=0 cmd_stoch=1 -> inference high 1 cycle, chip_clk 1 cycle high, stoch_log=1 for 3 cycles.
REQ-036 cmd_op=7 -> rsp_valid next cycle with rsp_err=1, rsp_data=0, no chip strobe.
REQ-037 rst_n low during 2nd cycle of 5-cycle LOAD_MEM pulse -> load_mem and all chip outputs 0 asynchronously; no response; next command accepted.
REQ-038 Back-to-back LOAD_SEED seeds=0x5A then 0xA5 with cmd_valid held -> two separate load_seed pulses, seeds matching each, cmd_* change mid-op ignored.
